// File: rtl/fifo_arb_pkg.sv
// Purpose : shared definitions for the FIFO write arbiter (FSM encoding, width helper).
// Latency : n/a (package only).
// Backpress: n/a (package only).
//
// Contents:
//   arb_state_e : two-state arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   clog2()     : ceiling log2, usable in parameter and port-width expressions
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2 of value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose : rotating-priority picker; first valid requester at or above rr_ptr, wrapping.
// Latency : purely combinational, zero cycles.
// Backpress: none; the caller decides when the pick is used.
//
// Ports:
//   req_valid [NREQ-1:0]  in   per-requester valid
//   rr_ptr    [IDX_W-1:0] in   index with highest priority this cycle
//   any_valid             out  at least one requester is valid
//   pick_idx  [IDX_W-1:0] out  chosen index (0 when any_valid = 0)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_valid,
  output logic [IDX_W-1:0] pick_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk NREQ positions starting at rr_ptr; modulo keeps the walk correct
  // when NREQ is not a power of two.
  always_comb begin
    any_valid = 1'b0;
    pick_idx  = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand     = (int'(rr_ptr) + i) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!any_valid && req_valid[cand_idx]) begin
        any_valid = 1'b1;
        pick_idx  = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin burst arbiter merging NREQ requesters onto one FIFO write port.
// Latency : 1 cycle from valid to grant; beats then pass combinationally (valid -> winc).
// Backpress: wfull drops the owner's ready and freezes the grant; awfull ends the burst.
//
// Ports:
//   wclk, wrst                  write clock, synchronous active-high reset
//   req_valid/req_data/req_ready per-requester handshake, data at [i*DSIZE +: DSIZE]
//   winc, wdata                 FIFO write strobe and data
//   wfull, awfull               FIFO full / almost-full flags
//   grant_id, busy              current owner (meaningful while busy), grant held
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  input  logic                    wfull,
  input  logic                    awfull,
  output logic [clog2(NREQ)-1:0]  grant_id,
  output logic                    busy
);

  localparam int IDX_W = clog2(NREQ);
  localparam int CNT_W = clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_vld;
  logic             grant_open;
  logic             beat;
  logic             release_grant;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .pick_idx  (pick_idx)
  );

  // Owner-side mux. Ready is gated by wfull directly so a beat can never
  // land in a full FIFO, even on the cycle wfull rises.
  always_comb begin
    grant_open = (state_q == ST_GRANT) && !wfull;
    owner_vld  = 1'b0;
    wdata      = '0;
    req_ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_vld    = req_valid[i];
        wdata        = req_data[i*DSIZE +: DSIZE];
        req_ready[i] = grant_open;
      end
    end
    beat = grant_open && owner_vld;
    winc = beat;
  end

  // Next-state logic. While wfull is high nothing moves: the owner keeps the
  // grant whatever it does with valid, and the burst counter holds.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    release_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!wfull) begin
          if (beat) begin
            // Last permitted beat, or the FIFO is nearly full: hand over.
            if ((cnt_q == LAST_BEAT) || awfull) begin
              release_grant = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Owner has nothing to send while the FIFO has room.
            release_grant = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (release_grant) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_GRANT);
  assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : self-checking bench for fifo_wr_arbiter (directed vectors plus randomised run).
// Latency : n/a.
// Backpress: FIFO occupancy model drives wfull/awfull in the randomised run.
module tb_fifo_wr_arbiter;

  localparam int DSIZE        = 8;
  localparam int NREQ         = 4;
  localparam int MAX_BURST    = 4;
  localparam int DEPTH        = 8;
  localparam int STARVE_BOUND = (NREQ - 1) * MAX_BURST + NREQ;

  logic                    wclk;
  logic                    wrst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic                    wfull;
  logic                    awfull;
  logic [1:0]              grant_id;
  logic                    busy;

  // Second instance with single-beat bursts, sharing all inputs.
  logic [NREQ-1:0]         rdy1;
  logic                    winc1;
  logic [DSIZE-1:0]        wdata1;
  logic [1:0]              gid1;
  logic                    busy1;

  int   n_checks = 0;
  int   n_err    = 0;
  int   step     = 0;
  logic last_rst = 1'b0;

  logic [DSIZE-1:0] sbq [NREQ][$];

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       f;
    logic       af;
    logic       eb;
    logic [1:0] eg;
    logic [3:0] er;
    logic       ew;
  } vec_t;

  vec_t tbl [12];

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) u_dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .awfull(awfull), .grant_id(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(1)) u_dut1 (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .winc(winc1), .wdata(wdata1), .wfull(wfull),
    .awfull(awfull), .grant_id(gid1), .busy(busy1)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold reset for two edges with all requesters valid; outputs must stay quiet.
  task automatic reset_chk(input string tag);
    wrst      = 1'b1;
    req_valid = '1;
    wfull     = 1'b0;
    awfull    = 1'b0;
    @(negedge wclk);
    @(posedge wclk); #1;
    @(negedge wclk);
    check({tag, " rst busy"}, 32'(busy), 32'd0);
    check({tag, " rst ready"}, 32'(req_ready), 32'd0);
    check({tag, " rst winc"}, 32'(winc), 32'd0);
    check({tag, " rst gid"}, 32'(grant_id), 32'd0);
    @(posedge wclk); #1;
    last_rst = 1'b1;
    step     = 0;
  endtask

  // One cycle: drive inputs, compare outputs at the falling edge, advance.
  task automatic cyc(input string tag, input logic rst, input logic [3:0] vld,
                     input logic f, input logic af, input logic eb,
                     input logic [1:0] eg, input logic [3:0] er, input logic ew);
    string nm;
    wrst      = rst;
    req_valid = vld;
    wfull     = f;
    awfull    = af;
    @(negedge wclk);
    nm = $sformatf("%s.%0d", tag, step);
    check({nm, " busy"}, 32'(busy), 32'(eb));
    check({nm, " ready"}, 32'(req_ready), 32'(er));
    check({nm, " winc"}, 32'(winc), 32'(ew));
    if (eb || last_rst) check({nm, " gid"}, 32'(grant_id), 32'(eg));
    if (ew) check({nm, " wdata"}, 32'(wdata), 32'({6'b101000, eg}));
    last_rst = rst;
    step++;
    @(posedge wclk); #1;
  endtask

  task automatic cyc1(input string tag, input logic [3:0] vld, input logic eb,
                      input logic [1:0] eg, input logic [3:0] er, input logic ew);
    string nm;
    wrst      = 1'b0;
    req_valid = vld;
    wfull     = 1'b0;
    awfull    = 1'b0;
    @(negedge wclk);
    nm = $sformatf("%s.%0d", tag, step);
    check({nm, " busy"}, 32'(busy1), 32'(eb));
    check({nm, " ready"}, 32'(rdy1), 32'(er));
    check({nm, " winc"}, 32'(winc1), 32'(ew));
    if (eb) check({nm, " gid"}, 32'(gid1), 32'(eg));
    step++;
    @(posedge wclk); #1;
  endtask

  // Random traffic against a FIFO occupancy model. Each requester holds a
  // presented word until accepted; the word is queued when presented and
  // must appear on wdata, in order, when that requester is granted.
  task automatic random_run(input int ncyc);
    int              count;
    int              w_prev;
    int              r_prev;
    int              rd_pct;
    int              wait_b [NREQ];
    int              max_wait;
    int              n_beats;
    logic [5:0]      seq [NREQ];
    logic [NREQ-1:0] acc_prev;
    logic [NREQ-1:0] beats;
    logic [1:0]      id;
    logic [DSIZE-1:0] word;
    count    = 0;
    w_prev   = 0;
    r_prev   = 0;
    max_wait = 0;
    n_beats  = 0;
    acc_prev = '0;
    for (int i = 0; i < NREQ; i++) begin
      wait_b[i] = 0;
      seq[i]    = '0;
      sbq[i].delete();
    end
    wrst      = 1'b0;
    req_valid = '0;
    for (int c = 0; c < ncyc; c++) begin
      count  = count + w_prev - r_prev;
      wfull  = (count >= DEPTH);
      awfull = (count >= DEPTH - 2);
      for (int i = 0; i < NREQ; i++) begin
        id = 2'(i);
        if (acc_prev[i]) begin
          seq[i]       = seq[i] + 6'd1;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && ($urandom_range(3) != 0)) begin
          word = {id, seq[i]};
          req_valid[i] = 1'b1;
          req_data[i*DSIZE +: DSIZE] = word;
          sbq[i].push_back(word);
        end
      end
      rd_pct = ((c / 1000) % 2 == 1) ? 30 : 85;
      r_prev = (count > 0 && $urandom_range(99) < rd_pct) ? 1 : 0;
      @(negedge wclk);
      beats = req_valid & req_ready;
      check("rnd ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("rnd winc_is_beat", 32'(winc), 32'(|beats));
      if (winc) begin
        n_beats++;
        check("rnd no_write_full", 32'(wfull), 32'd0);
        check("rnd beat_owner", 32'(beats[grant_id]), 32'd1);
        check("rnd sb_nonempty", 32'(sbq[grant_id].size() != 0), 32'd1);
        if (sbq[grant_id].size() != 0) begin
          word = sbq[grant_id].pop_front();
          check($sformatf("rnd data_order req%0d", grant_id), 32'(wdata), 32'(word));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (beats[i] || !req_valid[i]) begin
          wait_b[i] = 0;
        end else if (winc) begin
          wait_b[i]++;
          if (wait_b[i] > max_wait) max_wait = wait_b[i];
        end
      end
      acc_prev = beats;
      w_prev   = winc ? 1 : 0;
      @(posedge wclk); #1;
    end
    check("rnd starvation_bound", 32'(max_wait <= STARVE_BOUND), 32'd1);
    check("rnd traffic_seen", 32'(n_beats > 2000), 32'd1);
  endtask

  initial begin
    wrst      = 1'b1;
    req_valid = '0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    wfull     = 1'b0;
    awfull    = 1'b0;

    // Two requesters always valid: 4 beats req0, idle, 4 beats req2, idle, req0.
    tbl[0]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[2]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[3]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[4]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[5]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[6]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[7]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[8]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[9]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[10] = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};

    @(posedge wclk); #1;
    reset_chk("rr");
    for (int k = 0; k < 12; k++) begin
      cyc("rr", tbl[k].rst, tbl[k].vld, tbl[k].f, tbl[k].af,
          tbl[k].eb, tbl[k].eg, tbl[k].er, tbl[k].ew);
    end

    // wfull stall in the middle of req1's burst: grant held, counter frozen.
    reset_chk("full");
    cyc("full", 0, 4'b0010, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("full", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("full", 0, 4'b0010, 1, 0, 1, 2'd1, 4'b0000, 0);
    cyc("full", 0, 4'b0000, 1, 0, 1, 2'd1, 4'b0000, 0);
    cyc("full", 0, 4'b0010, 1, 0, 1, 2'd1, 4'b0000, 0);
    cyc("full", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("full", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("full", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("full", 0, 4'b0010, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("full", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);

    // awfull on beat 2 of req3 ends the grant; pointer then wraps to 0.
    reset_chk("afull");
    cyc("afull", 0, 4'b0010, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("afull", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("afull", 0, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 0);
    cyc("afull", 0, 4'b1000, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("afull", 0, 4'b1000, 0, 0, 1, 2'd3, 4'b1000, 1);
    cyc("afull", 0, 4'b1000, 0, 1, 1, 2'd3, 4'b1000, 1);
    cyc("afull", 0, 4'b1011, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("afull", 0, 4'b1011, 0, 0, 1, 2'd0, 4'b0001, 1);

    // req2 drops valid after one beat with everyone valid: next grant is req3.
    reset_chk("drop");
    cyc("drop", 0, 4'b0010, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("drop", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("drop", 0, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 0);
    cyc("drop", 0, 4'b1111, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("drop", 0, 4'b1111, 0, 0, 1, 2'd2, 4'b0100, 1);
    cyc("drop", 0, 4'b1011, 0, 0, 1, 2'd2, 4'b0100, 0);
    cyc("drop", 0, 4'b1111, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("drop", 0, 4'b1111, 0, 0, 1, 2'd3, 4'b1000, 1);

    // Reset on beat 3 of req2: quiet next cycle, search restarts at req0.
    reset_chk("mrst");
    cyc("mrst", 0, 4'b0010, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("mrst", 0, 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
    cyc("mrst", 0, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 0);
    cyc("mrst", 0, 4'b0110, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("mrst", 0, 4'b0110, 0, 0, 1, 2'd2, 4'b0100, 1);
    cyc("mrst", 0, 4'b0110, 0, 0, 1, 2'd2, 4'b0100, 1);
    cyc("mrst", 1, 4'b0110, 0, 0, 1, 2'd2, 4'b0100, 1);
    cyc("mrst", 0, 4'b0110, 0, 0, 0, 2'd0, 4'b0000, 0);
    cyc("mrst", 0, 4'b0110, 0, 0, 1, 2'd1, 4'b0010, 1);

    // Single-beat bursts alternate between requesters with one idle between.
    reset_chk("mb1");
    cyc1("mb1", 4'b0101, 0, 2'd0, 4'b0000, 0);
    cyc1("mb1", 4'b0101, 1, 2'd0, 4'b0001, 1);
    cyc1("mb1", 4'b0101, 0, 2'd0, 4'b0000, 0);
    cyc1("mb1", 4'b0101, 1, 2'd2, 4'b0100, 1);
    cyc1("mb1", 4'b0101, 0, 2'd0, 4'b0000, 0);
    cyc1("mb1", 4'b0101, 1, 2'd0, 4'b0001, 1);

    reset_chk("rnd");
    random_run(10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
